demux_vc: RTL and testbench

Registered, parametrised N-way demultiplexer that sits between a show-ahead upstream FIFO and NUM_CH downstream virtual-channel FIFOs. Each cycle it pops at most one word and routes it to exactly one channel. The destination comes either from an external selector or from a channel-id field carried in the word itself. It honours per-channel full backpressure, drops words with an out-of-range id, and keeps saturating per-channel delivery counters.

---
 rtl/demux_vc.sv | 103 ++++++++++
 tb/tb_demux_vc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/demux_vc.sv
// demux_vc: registered N-way demultiplexer from a show-ahead upstream FIFO
// into NUM_CH downstream virtual-channel FIFOs. At most one word is popped
// per cycle and routed to exactly one channel, chosen either by the external
// selector or by the channel-id field in the top bits of the word. Words whose
// id is out of range are consumed and flagged on err. Per-channel saturating
// counters track how many words each channel has received.
module demux_vc #(
    parameter int DATA_SIZE = 6,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = $clog2(NUM_CH),
    parameter int SEL_MODE  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en_pop,
    input  logic                        in_valid,
    input  logic [DATA_SIZE-1:0]        data_in,
    input  logic [SEL_W-1:0]            selector,
    input  logic [NUM_CH-1:0]           out_full,
    output logic                        pop,
    output logic [NUM_CH-1:0]           push,
    output logic [NUM_CH*DATA_SIZE-1:0] data_out,
    output logic                        err,
    output logic [NUM_CH*CNT_W-1:0]     cnt
);

    // NUM_CH widened by one bit so the range compare is exact for any NUM_CH.
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    logic [SEL_W-1:0]            dest;
    logic                        bad;
    logic                        dest_full;
    logic                        pop_c;

    logic [NUM_CH-1:0]           push_q, push_d;
    logic [NUM_CH*DATA_SIZE-1:0] data_q, data_d;
    logic                        err_q, err_d;
    logic [NUM_CH*CNT_W-1:0]     cnt_q, cnt_d;

    // Destination decode: id field of the head word or the external selector.
    always_comb begin
        dest = (SEL_MODE != 0) ? data_in[DATA_SIZE-1 -: SEL_W] : selector;
        bad  = ({1'b0, dest} >= NUM_CH_W);
    end

    // Pop decision and next-state for the registered lanes, pulse and counters.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        dest_full = 1'b0;
        push_d    = '0;
        data_d    = '0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;

        // Full flag of the addressed channel; stays 0 for an out-of-range id.
        for (int i = 0; i < NUM_CH; i++) begin
            if (dest == SEL_W'(i)) begin
                dest_full = out_full[i];
            end
        end

        // A bad word never waits on backpressure: it is always discarded.
        pop_c = !reset && en_pop && in_valid && (bad || !dest_full);
        err_d = pop_c && bad;

        for (int i = 0; i < NUM_CH; i++) begin
            if (pop_c && !bad && (dest == SEL_W'(i))) begin
                push_d[i]                          = 1'b1;
                data_d[i*DATA_SIZE +: DATA_SIZE]   = data_in;
                // Hold at all-ones instead of wrapping.
                if (!(&cnt_q[i*CNT_W +: CNT_W])) begin
                    cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Output and counter registers; reset clears them without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            push_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            push_q <= push_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pop      = pop_c;
    assign push     = push_q;
    assign data_out = data_q;
    assign err      = err_q;
    assign cnt      = cnt_q;

endmodule

// File: tb/tb_demux_vc.sv
// tb_demux_vc: directed bench for demux_vc. Instance A uses id-in-word routing
// with three channels (exercises out-of-range ids); instance B uses the
// external selector with four channels and 2-bit counters (saturation).
module tb_demux_vc;

    logic clk;
    logic reset;

    // Instance A: DATA_SIZE=6, NUM_CH=3, SEL_MODE=1, CNT_W=8
    logic        a_en_pop, a_in_valid, a_pop, a_err;
    logic [5:0]  a_data_in;
    logic [1:0]  a_selector;
    logic [2:0]  a_out_full, a_push;
    logic [17:0] a_data_out;
    logic [23:0] a_cnt;

    // Instance B: DATA_SIZE=6, NUM_CH=4, SEL_MODE=0, CNT_W=2
    logic        b_en_pop, b_in_valid, b_pop, b_err;
    logic [5:0]  b_data_in;
    logic [1:0]  b_selector;
    logic [3:0]  b_out_full, b_push;
    logic [23:0] b_data_out;
    logic [7:0]  b_cnt;

    int checks   = 0;
    int failures = 0;

    demux_vc #(.DATA_SIZE(6), .NUM_CH(3), .SEL_MODE(1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en_pop(a_en_pop), .in_valid(a_in_valid),
        .data_in(a_data_in), .selector(a_selector), .out_full(a_out_full),
        .pop(a_pop), .push(a_push), .data_out(a_data_out), .err(a_err), .cnt(a_cnt)
    );

    demux_vc #(.DATA_SIZE(6), .NUM_CH(4), .SEL_MODE(0), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .en_pop(b_en_pop), .in_valid(b_in_valid),
        .data_in(b_data_in), .selector(b_selector), .out_full(b_out_full),
        .pop(b_pop), .push(b_push), .data_out(b_data_out), .err(b_err), .cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset      = 1'b1;
        a_en_pop   = 1'b1; a_in_valid = 1'b1; a_data_in = 6'b10_1011;
        a_selector = 2'd0; a_out_full = 3'b000;
        b_en_pop   = 1'b1; b_in_valid = 1'b0; b_data_in = 6'd0;
        b_selector = 2'd0; b_out_full = 4'b0000;

        // Reset state
        #1;
        check("rst_a_pop",  a_pop, 1'b0);
        check("rst_a_push", a_push, 3'b000);
        check("rst_a_data", a_data_out, 18'h0);
        check("rst_a_err",  a_err, 1'b0);
        check("rst_a_cnt",  a_cnt, 24'h0);
        check("rst_b_push", b_push, 4'b0000);
        check("rst_b_cnt",  b_cnt, 8'h0);

        // Routing by id field: 10_1011 -> channel 2
        next();
        reset = 1'b0;
        #1;
        check("route_pop", a_pop, 1'b1);
        next();
        check("route_push", a_push, 3'b100);
        check("route_data", a_data_out, {6'h2B, 6'h00, 6'h00});
        check("route_cnt",  a_cnt, 24'h01_00_00);
        check("route_err",  a_err, 1'b0);

        // Out-of-range id 3 with three channels: dropped, err pulse
        a_data_in = 6'b11_0001;
        #1;
        check("bad_pop", a_pop, 1'b1);
        next();
        check("bad_err",  a_err, 1'b1);
        check("bad_push", a_push, 3'b000);
        check("bad_data", a_data_out, 18'h0);
        check("bad_cnt",  a_cnt, 24'h01_00_00);

        // Backpressure on channel 1 for three cycles
        a_data_in  = 6'b01_0101;
        a_out_full = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_pop_blocked", a_pop, 1'b0);
            next();
            check("bp_push_idle", a_push, 3'b000);
            check("bp_err_idle",  a_err, 1'b0);
        end
        a_out_full = 3'b000;
        #1;
        check("bp_pop_release", a_pop, 1'b1);
        next();
        check("bp_push", a_push, 3'b010);
        check("bp_data", a_data_out, {6'h00, 6'h15, 6'h00});
        check("bp_cnt",  a_cnt, 24'h01_01_00);

        // Upstream empty: no pop, lanes return to zero
        a_in_valid = 1'b0;
        #1;
        check("idle_pop", a_pop, 1'b0);
        next();
        check("idle_push", a_push, 3'b000);
        check("idle_data", a_data_out, 18'h0);

        // Global enable low freezes the block
        a_in_valid = 1'b1;
        a_en_pop   = 1'b0;
        #1;
        check("en_pop_low", a_pop, 1'b0);
        next();
        check("en_push_low", a_push, 3'b000);
        check("en_cnt_hold", a_cnt, 24'h01_01_00);
        a_in_valid = 1'b0;
        a_en_pop   = 1'b1;

        // Back-to-back routing by selector, one word per cycle
        b_in_valid = 1'b1;
        b_selector = 2'd0; b_data_in = 6'd1;
        #1;
        check("b2b_pop", b_pop, 1'b1);
        next();
        check("b2b_push0", b_push, 4'b0001);
        check("b2b_data0", b_data_out, 24'h00_0001);
        b_selector = 2'd1; b_data_in = 6'd2;
        next();
        check("b2b_push1", b_push, 4'b0010);
        check("b2b_data1", b_data_out, 24'h00_0080);
        b_selector = 2'd2; b_data_in = 6'd3;
        next();
        check("b2b_push2", b_push, 4'b0100);
        check("b2b_data2", b_data_out, 24'h00_3000);
        b_selector = 2'd3; b_data_in = 6'd4;
        next();
        check("b2b_push3", b_push, 4'b1000);
        check("b2b_data3", b_data_out, 24'h10_0000);
        check("b2b_cnt",   b_cnt, 8'b01_01_01_01);

        // Stream to channel 1, then reset in mid-cycle
        b_selector = 2'd1; b_data_in = 6'h2A;
        next();
        check("rst_mid_push_before", b_push, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_push", b_push, 4'b0000);
        check("rst_mid_data", b_data_out, 24'h0);
        check("rst_mid_cnt",  b_cnt, 8'h0);
        check("rst_mid_err",  b_err, 1'b0);
        check("rst_mid_pop",  b_pop, 1'b0);
        check("rst_mid_a_cnt", a_cnt, 24'h0);
        next();
        reset = 1'b0;

        // Saturation with 2-bit counters: five words to channel 0
        b_selector = 2'd0;
        for (int k = 0; k < 5; k++) begin
            b_data_in = 6'(k + 1);
            next();
            check("sat_push", b_push, 4'b0001);
            check("sat_cnt0", b_cnt[1:0], sat_exp[k]);
        end
        check("sat_cnt_others", b_cnt[7:2], 6'h0);

        b_in_valid = 1'b0;
        next();
        check("final_push", b_push, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
